// File: rtl/sram_bist.sv
// sram_bist: four-pass march self-test driving the SRAM controller command port.
// Define SRAM_BIST_STOP_ON_ERR_EN to end the test at the first read mismatch.
module sram_bist #(
   parameter int                ADDR_W    = 18,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}},
   parameter logic [DATA_W-1:0] PATTERN   = 16'hA55A
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ready,
   input  logic [DATA_W-1:0] data_s2f,
   output logic              mem,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_f2s,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data,
   output logic [15:0]       err_count
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FIN} state_t;
   state_t state, state_nxt;
   logic [1:0] pass, pass_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic last, mis, stop, fin, go;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
      return (DATA_W'(a) ^ PATTERN) ^ {DATA_W{inv}};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pass      <= '0;
         addr      <= '0;
         rw        <= 1'b1;
         data_f2s  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         err_addr  <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else begin
         state <= state_nxt;
         if (go) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_addr  <= '0;
            err_data  <= '0;
            err_count <= '0;
            pass      <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            data_f2s  <= pat('0, 1'b0);
         end
         if (state == NEXT) begin
            if (mis) begin
               if (!fail) begin
                  fail     <= 1'b1;
                  err_addr <= addr;
                  err_data <= data_s2f;
               end
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (fin) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               addr     <= addr_nxt;
               pass     <= pass_nxt;
               rw       <= pass_nxt[0];
               data_f2s <= pat(addr_nxt, pass_nxt[1]);
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FIN: state_nxt = start ? ISSUE : state;
         ISSUE:     state_nxt = ready ? WAIT : ISSUE;
         WAIT:      state_nxt = ready ? NEXT : WAIT;
         NEXT:      state_nxt = fin ? FIN : ISSUE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem      = state == ISSUE;
      go       = (state == IDLE || state == FIN) && start;
      last     = addr == ADDR_LAST;
      addr_nxt = last ? '0 : addr + ADDR_W'(1);
      pass_nxt = last ? pass + 2'd1 : pass;
      mis      = state == NEXT && rw && data_s2f != pat(addr, pass[1]);
`ifdef SRAM_BIST_STOP_ON_ERR_EN
      stop     = mis;
`else
      stop     = 1'b0;
`endif
      fin      = stop || (last && pass == 2'd3);
   end
endmodule

// File: tb/tb_sram_bist.sv
// tb_sram_bist: scoreboard bench; lane 0 tests ADDR_LAST=3 against a controller/SRAM model, lane 1 ADDR_LAST=0.
module tb_sram_bist;
   localparam int AW = 18;
   localparam int DW = 16;
`ifdef SRAM_BIST_STOP_ON_ERR_EN
   localparam int NFAULT = 7;
`else
   localparam int NFAULT = 16;
`endif
   localparam logic [DW-1:0] WD[8] = '{16'hA55A, 16'hA55B, 16'hA558, 16'hA559,
                                       16'h5AA5, 16'h5AA4, 16'h5AA7, 16'h5AA6};

   logic clk = 0, reset = 1, start0 = 0, start1 = 0;
   logic ready0, ready1;
   logic [DW-1:0] s2f0, s2f1;
   logic mem0, rw0, busy0, done0, fail0, mem1, rw1, busy1, done1, fail1;
   logic [AW-1:0] addr0, err_addr0, addr1, err_addr1;
   logic [DW-1:0] data0, err_data0, data1, err_data1;
   logic [15:0] err_count0, err_count1;
   int vectors = 0, miscompares = 0;
   int extra = 0, cnt0 = 0, cnt1 = 0;
   logic stuck = 0;
   logic [DW-1:0] sram[4];
   logic [DW-1:0] word1;
   logic [34:0] q0[$], q1[$];
   logic [34:0] e0, e1, held0;
   logic hold0 = 0;

   always #5 clk = ~clk;

   sram_bist #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(18'd3), .PATTERN(16'hA55A)) u0 (
      .clk(clk), .reset(reset), .start(start0), .ready(ready0), .data_s2f(s2f0),
      .mem(mem0), .rw(rw0), .addr(addr0), .data_f2s(data0), .busy(busy0), .done(done0),
      .fail(fail0), .err_addr(err_addr0), .err_data(err_data0), .err_count(err_count0));

   sram_bist #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LAST(18'd0), .PATTERN(16'hA55A)) u1 (
      .clk(clk), .reset(reset), .start(start1), .ready(ready1), .data_s2f(s2f1),
      .mem(mem1), .rw(rw1), .addr(addr1), .data_f2s(data1), .busy(busy1), .done(done1),
      .fail(fail1), .err_addr(err_addr1), .err_data(err_data1), .err_count(err_count1));

   // Controller + SRAM model: ready drops for 1+extra cycles after each accept.
   always @(posedge clk) begin
      if (reset) begin
         ready0 <= 1'b1;
         cnt0   <= 0;
      end else if (cnt0 != 0) begin
         cnt0 <= cnt0 - 1;
         if (cnt0 == 1) ready0 <= 1'b1;
      end else if (mem0 && ready0) begin
         ready0 <= 1'b0;
         cnt0   <= 1 + extra;
         if (rw0) s2f0 <= sram[addr0[1:0]];
         else sram[addr0[1:0]] <= (stuck && addr0 == 18'd2) ? (data0 | 16'h0001) : data0;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         ready1 <= 1'b1;
         cnt1   <= 0;
      end else if (cnt1 != 0) begin
         cnt1 <= cnt1 - 1;
         if (cnt1 == 1) ready1 <= 1'b1;
      end else if (mem1 && ready1) begin
         ready1 <= 1'b0;
         cnt1   <= 1;
         if (rw1) s2f1 <= word1;
         else word1 <= data1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: pop one expected command per accept; reads compare rw/addr only.
   always @(negedge clk) begin
      if (reset || !mem0) hold0 = 1'b0;
      else begin
         if (hold0) chk("cmd0 held stable", {rw0, addr0, data0}, held0);
         if (ready0) begin
            hold0 = 1'b0;
            if (q0.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL cmd0 unexpected: got %0h, expected no command", {rw0, addr0, data0});
            end else begin
               e0 = q0.pop_front();
               chk("cmd0", {rw0, addr0, rw0 ? 16'h0 : data0}, {e0[34:16], e0[34] ? 16'h0 : e0[15:0]});
            end
         end else begin
            hold0 = 1'b1;
            held0 = {rw0, addr0, data0};
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && mem1 && ready1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd1 unexpected: got %0h, expected no command", {rw1, addr1, data1});
         end else begin
            e1 = q1.pop_front();
            chk("cmd1", {rw1, addr1, rw1 ? 16'h0 : data1}, {e1[34:16], e1[34] ? 16'h0 : e1[15:0]});
         end
      end
   end

   task automatic push0(input int n);
      for (int i = 0; i < n; i++) begin
         logic [1:0] p, a;
         p = 2'(i / 4);
         a = 2'(i % 4);
         q0.push_back({p[0], 16'h0, a, p[1] ? WD[4 + a] : WD[a]});
      end
   endtask

   task automatic pulse0();
      @(posedge clk); #1 start0 = 1;
      @(posedge clk); #1 start0 = 0;
   endtask

   task automatic wait_done0(input int bound);
      int n = 0;
      while (!done0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("done0 in time", done0, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset mem/rw/busy/done/fail", {mem0, rw0, busy0, done0, fail0}, 5'b01000);
      chk("reset addr/data", {addr0, data0}, 0);
      chk("reset err", {err_addr0, err_data0, err_count0}, 0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("no cmd after reset", mem0, 0);
      // Clean run
      push0(16);
      pulse0();
      wait_done0(70);
      chk("clean fail/count", {fail0, err_count0}, 0);
      chk("clean queue empty", q0.size(), 0);
      // Address 2 bit 0 stuck at 1
      stuck = 1;
      push0(NFAULT);
      pulse0();
      wait_done0(70);
      chk("fault fail", fail0, 1);
      chk("fault err_addr", err_addr0, 2);
      chk("fault err_data", err_data0, 16'hA559);
      chk("fault err_count", err_count0, 1);
      repeat (4) @(negedge clk);
      chk("fault queue empty", q0.size(), 0);
      // Restart from FIN clears errors
      stuck = 0;
      push0(16);
      pulse0();
      @(negedge clk);
      chk("restart busy/done/fail", {busy0, done0, fail0}, 3'b100);
      chk("restart err cleared", {err_addr0, err_data0, err_count0}, 0);
      wait_done0(70);
      chk("restart fail", fail0, 0);
      chk("restart queue empty", q0.size(), 0);
      // Slow controller plus ignored start while busy
      extra = 5;
      push0(16);
      pulse0();
      repeat (20) @(posedge clk);
      pulse0();
      @(negedge clk);
      chk("busy after ignored start", busy0, 1);
      wait_done0(200);
      chk("slow fail/count", {fail0, err_count0}, 0);
      chk("slow queue empty", q0.size(), 0);
      extra = 0;
      // Reset during pass 2
      stuck = 1;
      push0(NFAULT);
      pulse0();
      repeat (36) @(posedge clk);
      #1 chk("err before reset", err_count0, 1);
      reset = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("reset abort mem/busy/done", {mem0, busy0, done0}, 0);
      chk("reset abort err_count", err_count0, 0);
      q0.delete();
      stuck = 0;
      push0(16);
      pulse0();
      wait_done0(70);
      chk("post-reset fail/count", {fail0, err_count0}, 0);
      chk("post-reset queue empty", q0.size(), 0);
      // ADDR_LAST = 0
      q1.push_back({1'b0, 18'd0, 16'hA55A});
      q1.push_back({1'b1, 18'd0, 16'h0});
      q1.push_back({1'b0, 18'd0, 16'h5AA5});
      q1.push_back({1'b1, 18'd0, 16'h0});
      @(posedge clk); #1 start1 = 1;
      @(posedge clk); #1 start1 = 0;
      for (int n = 0; n < 30 && !done1; n++) @(negedge clk);
      chk("lane1 done", done1, 1);
      chk("lane1 fail/count", {fail1, err_count1}, 0);
      chk("lane1 queue empty", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
